anton_neopixel_apb_multi: RTL and testbench

//  APB3 slave driving CHANNELS independent WS2812 strips from one clock, with on-chip GRB pixel RAM,

---
 rtl/anton_neopixel_apb_multi.sv | 234 +++++++++++++++++++++++
 tb/tb_anton_neopixel_apb_multi.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/anton_neopixel_apb_multi.sv
// APB3 slave driving CHANNELS WS2812 strips from a GRB pixel RAM, serialized one channel at a time.
// Optional ANTON_NEOPIXEL_DOUBLE_BUFFER_EN: front/back RAM banks swapped at every frame start.
module anton_neopixel_apb_multi #(
  parameter int CHANNELS     = 4,
  parameter int PIXELS_MAX   = 66,
  parameter int T0H_CYCLES   = 20,
  parameter int T1H_CYCLES   = 40,
  parameter int BIT_CYCLES   = 63,
  parameter int RESET_CYCLES = 2500
) (
  input  logic                apbPclk,
  input  logic                apbPreset,
  input  logic                apbPselx,
  input  logic                apbPenable,
  input  logic                apbPwrite,
  input  logic [31:0]         apbPaddr,
  input  logic [31:0]         apbPwData,
  output logic [31:0]         apbPrData,
  output logic                apbPready,
  output logic                apbPslverr,
  output logic [CHANNELS-1:0] neoData,
  output logic                neoState,
  output logic                pixelsSync
);
  localparam int CB   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PB   = (PIXELS_MAX > 1) ? $clog2(PIXELS_MAX) : 1;
  localparam int CBP  = CB + 1;
  localparam int LW   = PB + 1;
  localparam int RW   = PB + CB;
  localparam int MAXC = (RESET_CYCLES > BIT_CYCLES) ? RESET_CYCLES : BIT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  // Handshake: a transfer completes on the rising edge where apbPselx, apbPenable and
  // apbPready are all 1; apbPrData/apbPslverr are only meaningful in that cycle.

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_HIGH, S_LOW, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      bit_q, bit_d;
  logic [23:0]     shift_q, shift_d;
  logic [CB-1:0]   ch_q, ch_d;
  logic [PB-1:0]   px_q, px_d;
  logic [LW-1:0]   lenact_q, lenact_d;
  logic            frame_start;

  logic            loop_q, done_q, ovr_q, rd_pend_q;
  logic [LW-1:0]   len_q;
  logic [23:0]     prd_q;

  logic            acc, wr, rd, pix_sel, pix_ok, pix_rd, apb_issue;
  logic            reg_ctrl, reg_stat, reg_len, len_ok, start_req, gap_end;
  logic [CB-1:0]   pix_ch;
  logic [PB-1:0]   pix_px;
  logic [RW-1:0]   reg_idx;
  logic            port_free;
  logic [23:0]     ser_rd_data, apb_rd_data;
  logic            unused_ok;

  assign acc       = apbPselx & apbPenable;
  assign wr        = acc & apbPwrite;
  assign rd        = acc & ~apbPwrite;
  assign pix_sel   = apbPaddr[2+RW];
  assign pix_ch    = apbPaddr[2+PB +: CB];
  assign pix_px    = apbPaddr[2 +: PB];
  assign reg_idx   = apbPaddr[2 +: RW];
  assign pix_ok    = pix_sel & ({1'b0, pix_ch} < CBP'(CHANNELS)) & ({1'b0, pix_px} < LW'(PIXELS_MAX));
  assign reg_ctrl  = ~pix_sel & (reg_idx == '0);
  assign reg_stat  = ~pix_sel & (reg_idx == RW'(1));
  assign reg_len   = ~pix_sel & (reg_idx == RW'(2));
  assign len_ok    = (apbPwData != 32'd0) & (apbPwData <= 32'(PIXELS_MAX));
  assign start_req = wr & reg_ctrl & apbPwData[0];
  assign gap_end   = (state_q == S_GAP) & (cnt_q == CW'(RESET_CYCLES - 1));
  assign pix_rd    = rd & pix_ok;
  assign apb_issue = pix_rd & ~rd_pend_q & port_free;
  assign unused_ok = ^{apbPaddr[31:3+RW], apbPaddr[1:0]};

`ifdef ANTON_NEOPIXEL_DOUBLE_BUFFER_EN
  localparam int AW = RW + 1;
  logic          bank_q;
  logic [AW-1:0] apb_ram_addr;
  logic [23:0]   ram [2**AW];
  assign apb_ram_addr = {~bank_q, pix_ch, pix_px};
  assign ser_rd_data  = ram[{bank_q, ch_q, px_q}];
  assign apb_rd_data  = ram[apb_ram_addr];
  assign port_free    = 1'b1;
  always_ff @(posedge apbPclk or posedge apbPreset) begin
    if (apbPreset) bank_q <= 1'b0;
    else if (frame_start) bank_q <= ~bank_q;
  end
`else
  localparam int AW = RW;
  logic [AW-1:0] apb_ram_addr;
  logic [23:0]   ram [2**AW];
  logic [23:0]   rd_data;
  // One read port: the serializer's FETCH wins, an APB read waits a cycle.
  assign apb_ram_addr = {pix_ch, pix_px};
  assign rd_data      = ram[(state_q == S_FETCH) ? {ch_q, px_q} : apb_ram_addr];
  assign ser_rd_data  = rd_data;
  assign apb_rd_data  = rd_data;
  assign port_free    = (state_q != S_FETCH);
`endif

  always_ff @(posedge apbPclk) begin
    if (wr & pix_ok) ram[apb_ram_addr] <= apbPwData[23:0];
  end

  assign apbPready  = acc & (~pix_rd | rd_pend_q);
  assign apbPslverr = acc & ((pix_sel & ~pix_ok) | (~pix_sel & ~(reg_ctrl | reg_stat | reg_len))
                             | (apbPwrite & reg_len & ~len_ok));

  always_comb begin
    apbPrData = 32'd0;
    if (rd & apbPready) begin
      if (pix_ok)        apbPrData = {8'd0, prd_q};
      else if (reg_ctrl) apbPrData = {30'd0, loop_q, 1'b0};
      else if (reg_stat) apbPrData = {29'd0, ovr_q, done_q, neoState};
      else if (reg_len)  apbPrData = {{(32-LW){1'b0}}, len_q};
    end
  end

  always_ff @(posedge apbPclk or posedge apbPreset) begin
    if (apbPreset) begin
      loop_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      len_q     <= LW'(PIXELS_MAX);
      rd_pend_q <= 1'b0;
      prd_q     <= 24'd0;
    end else begin
      if (wr & reg_ctrl) loop_q <= apbPwData[1];
      if (gap_end) done_q <= 1'b1;
      else if (wr & reg_stat & apbPwData[1]) done_q <= 1'b0;
      if (start_req & (state_q != S_IDLE)) ovr_q <= 1'b1;
      else if (wr & reg_stat & apbPwData[2]) ovr_q <= 1'b0;
      if (wr & reg_len & len_ok) len_q <= apbPwData[LW-1:0];
      rd_pend_q <= apb_issue;
      if (apb_issue) prd_q <= apb_rd_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    ch_d        = ch_q;
    px_d        = px_q;
    lenact_d    = lenact_q;
    frame_start = 1'b0;
    case (state_q)
      S_IDLE:  frame_start = start_req;
      S_FETCH: begin
        shift_d = ser_rd_data;
        bit_d   = 5'd23;
        cnt_d   = '0;
        state_d = S_HIGH;
      end
      S_HIGH: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == (shift_q[23] ? CW'(T1H_CYCLES - 1) : CW'(T0H_CYCLES - 1))) state_d = S_LOW;
      end
      S_LOW: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BIT_CYCLES - 1)) begin
          cnt_d = '0;
          if (bit_q == 5'd0) begin
            if ({1'b0, px_q} == lenact_q - LW'(1)) begin
              px_d = '0;
              if (ch_q == CB'(CHANNELS - 1)) state_d = S_GAP;
              else begin
                ch_d    = ch_q + CB'(1);
                state_d = S_FETCH;
              end
            end else begin
              px_d    = px_q + PB'(1);
              state_d = S_FETCH;
            end
          end else begin
            bit_d   = bit_q - 5'd1;
            shift_d = {shift_q[22:0], 1'b0};
            state_d = S_HIGH;
          end
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + CW'(1);
        if (gap_end) begin
          cnt_d       = '0;
          state_d     = S_IDLE;
          frame_start = loop_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (frame_start) begin
      state_d  = S_FETCH;
      ch_d     = '0;
      px_d     = '0;
      cnt_d    = '0;
      lenact_d = len_q;
    end
  end

  always_ff @(posedge apbPclk or posedge apbPreset) begin
    if (apbPreset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= 5'd0;
      shift_q  <= 24'd0;
      ch_q     <= '0;
      px_q     <= '0;
      lenact_q <= LW'(PIXELS_MAX);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      ch_q     <= ch_d;
      px_q     <= px_d;
      lenact_q <= lenact_d;
    end
  end

  always_comb begin
    neoData = '0;
    for (int i = 0; i < CHANNELS; i++)
      neoData[i] = (state_q == S_HIGH) & (ch_q == CB'(i));
  end

  assign neoState   = (state_q != S_IDLE);
  assign pixelsSync = gap_end;

endmodule

// File: tb/tb_anton_neopixel_apb_multi.sv
// Bench for anton_neopixel_apb_multi: directed APB vectors plus a timing model of the WS2812 frame.
module tb_anton_neopixel_apb_multi;
  localparam int CH = 4, PXM = 66, T0H = 20, T1H = 40, BIT = 63, RST = 2500;
  localparam int PXSLOT = 1 + 24 * BIT;

  logic          clk = 1'b0, rst;
  logic          psel, penable, pwrite;
  logic [31:0]   paddr, pwdata, prdata;
  logic          pready, pslverr;
  logic [CH-1:0] neo;
  logic          neo_state, pix_sync;

  anton_neopixel_apb_multi dut (
    .apbPclk(clk), .apbPreset(rst), .apbPselx(psel), .apbPenable(penable),
    .apbPwrite(pwrite), .apbPaddr(paddr), .apbPwData(pwdata), .apbPrData(prdata),
    .apbPready(pready), .apbPslverr(pslverr), .neoData(neo), .neoState(neo_state),
    .pixelsSync(pix_sync)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [31:0] exp_q[$];

  // Behavioural model: register state, pixel memory, and frame position.
  logic [23:0] mdl_mem [CH][PXM];
  logic [23:0] snap [CH][PXM];
  int          mdl_len = PXM, snap_len = PXM, mdl_t = 0, sync_cnt = 0;
  bit          mdl_loop = 0, mdl_done = 0, mdl_ovr = 0, mdl_active = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, expv);
    end
  endtask

  function automatic int frame_len(input int len);
    return CH * len * PXSLOT + RST;
  endfunction

  function automatic logic [CH-1:0] exp_neo(input int t);
    int slot_ch, c, r, p, q, b, ph;
    logic v;
    exp_neo = '0;
    slot_ch = snap_len * PXSLOT;
    if (t < CH * slot_ch) begin
      c = t / slot_ch; r = t % slot_ch; p = r / PXSLOT; q = r % PXSLOT;
      if (q != 0) begin
        b  = (q - 1) / BIT;
        ph = (q - 1) % BIT;
        v  = snap[c][p][23-b];
        if (ph < (v ? T1H : T0H)) exp_neo[c] = 1'b1;
      end
    end
  endfunction

  logic [CH-1:0] m_neo;
  logic          m_st, m_sy;
  always @(negedge clk) begin
    m_neo = '0; m_st = 1'b0; m_sy = 1'b0;
    if (mdl_active) begin
      m_neo = exp_neo(mdl_t);
      m_st  = 1'b1;
      m_sy  = (mdl_t == frame_len(snap_len) - 1);
    end
    total++;
    if ({neo, neo_state, pix_sync} !== {m_neo, m_st, m_sy}) begin
      bad++;
      $display("FAIL mon t=%0d: got neo=%b st=%b sync=%b want neo=%b st=%b sync=%b",
               mdl_t, neo, neo_state, pix_sync, m_neo, m_st, m_sy);
    end
    if (mdl_active) begin
      if (m_sy) begin
        sync_cnt++;
        mdl_done = 1'b1;
        if (mdl_loop) begin
          snap = mdl_mem; snap_len = mdl_len; mdl_t = 0;
        end else mdl_active = 1'b0;
      end else mdl_t++;
    end
  end

  function automatic logic [31:0] pa(input int c, input int p);
    return 32'h800 | (c << 9) | (p << 2);
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d);
    if (a[11]) begin
      if (a[8:2] < PXM) mdl_mem[a[10:9]][a[8:2]] = d[23:0];
    end else case (a[10:2])
      9'd0: begin
        mdl_loop = d[1];
        if (d[0]) begin
          if (mdl_active) mdl_ovr = 1'b1;
          else begin
            mdl_active = 1'b1; mdl_t = 0; snap = mdl_mem; snap_len = mdl_len;
          end
        end
      end
      9'd1: begin
        if (d[1]) mdl_done = 1'b0;
        if (d[2]) mdl_ovr = 1'b0;
      end
      9'd2: if (d >= 1 && d <= PXM) mdl_len = d;
      default: ;
    endcase
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, input logic exp_err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check($sformatf("wr_pready@%h", a), {31'd0, pready}, 32'd1);
    check($sformatf("wr_slverr@%h", a), {31'd0, pslverr}, {31'd0, exp_err});
    @(posedge clk); #1;
    mdl_write(a, d);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input string nm, input logic [31:0] a, input logic exp_err, input int exp_waits);
    logic [31:0] d, e;
    logic er;
    int w;
    bit got;
    d = '0; er = 1'b0; w = 0; got = 1'b0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (pready) begin d = prdata; er = pslverr; got = 1'b1; end
      else w++;
      @(posedge clk); #1;
    end
    psel = 1'b0; penable = 1'b0;
    e = exp_q.pop_front();
    check({nm, "_ready"}, {31'd0, got}, 32'd1);
    check({nm, "_data"}, d, e);
    check({nm, "_slverr"}, {31'd0, er}, {31'd0, exp_err});
    check({nm, "_waits"}, w, exp_waits);
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] e,
                    input logic exp_err, input int exp_waits);
    exp_q.push_back(e);
    apb_read(nm, a, exp_err, exp_waits);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (neo_state !== 1'b0 && n < budget) begin @(posedge clk); #1; n++; end
    check("frame_end", {31'd0, neo_state}, 32'd0);
  endtask

  task automatic wait_sync(input int target, input int budget);
    int n;
    n = 0;
    while (sync_cnt < target && n < budget) begin @(posedge clk); #1; n++; end
    check("sync_wait", sync_cnt, target);
  endtask

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    for (int c = 0; c < CH; c++) for (int p = 0; p < PXM; p++) mdl_mem[c][p] = '0;
    snap = mdl_mem;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs", {prdata, pready, pslverr, neo, neo_state, pix_sync}, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    rd("len_rst", 32'h8, 32'd66, 1'b0, 0);
    rd("stat_rst", 32'h4, 32'd0, 1'b0, 0);
    rd("ctrl_rst", 32'h0, 32'd0, 1'b0, 0);

    apb_write(pa(0, 0), 32'h00000000, 1'b0);
    apb_write(pa(1, 0), 32'h00800001, 1'b0);
    apb_write(pa(2, 0), 32'hAB5A3C81, 1'b0);
    apb_write(pa(3, 0), 32'h00FFFFFF, 1'b0);
    apb_write(pa(0, 1), 32'h000F0F0F, 1'b0);
    apb_write(pa(1, 1), 32'h00F0F0F0, 1'b0);
    apb_write(pa(2, 1), 32'h00000001, 1'b0);
    apb_write(pa(3, 1), 32'h00800000, 1'b0);
    rd("px_c2p0", pa(2, 0), 32'h005A3C81, 1'b0, 1);
    rd("px_c1p0", pa(1, 0), 32'h00800001, 1'b0, 1);
    rd("px_bad66", pa(0, 66), 32'd0, 1'b1, 0);
    rd("px_bad127", pa(3, 127), 32'd0, 1'b1, 0);
    rd("reg_bad3", 32'hC, 32'd0, 1'b1, 0);
    rd("reg_bad511", 32'h7FC, 32'd0, 1'b1, 0);
    apb_write(pa(1, 70), 32'h00123456, 1'b1);
    apb_write(32'h8, 32'd0, 1'b1);
    apb_write(32'h8, 32'd67, 1'b1);
    rd("len_kept", 32'h8, 32'd66, 1'b0, 0);
    apb_write(32'h8, 32'd1, 1'b0);
    rd("len_one", 32'h8, 32'd1, 1'b0, 0);

    // Frame 1: one pixel per channel.
    apb_write(32'h0, 32'd1, 1'b0);
    check("pin_len", frame_len(snap_len), 32'd8552);
    check("pin_t1", exp_neo(1), 32'h1);
    check("pin_t20", exp_neo(20), 32'h1);
    check("pin_t21", exp_neo(21), 32'h0);
    check("pin_t1513", exp_neo(1513), 32'h0);
    check("pin_t1514", exp_neo(1514), 32'h2);
    check("pin_t1553", exp_neo(1553), 32'h2);
    check("pin_t1554", exp_neo(1554), 32'h0);
    check("pin_t1596", exp_neo(1596), 32'h2);
    check("pin_t1597", exp_neo(1597), 32'h0);
    check("pin_t3002", exp_neo(3002), 32'h2);
    check("pin_t3003", exp_neo(3003), 32'h0);
    check("pin_t6052", exp_neo(6052), 32'h0);
    repeat (1511) @(posedge clk);
    rd("px_collide", pa(2, 0), 32'h005A3C81, 1'b0, 2);
    rd("stat_busy", 32'h4, 32'h1, 1'b0, 0);
    rd("px_nocoll", pa(3, 0), 32'h00FFFFFF, 1'b0, 1);
    wait_idle(10000);
    check("sync_one", sync_cnt, 32'd1);
    rd("stat_done", 32'h4, 32'h2, 1'b0, 0);
    apb_write(32'h4, 32'h6, 1'b0);
    rd("stat_clr", 32'h4, 32'h0, 1'b0, 0);

    // Looping frames, START while busy, then LOOP cleared mid-frame.
    apb_write(32'h0, 32'd3, 1'b0);
    repeat (100) @(posedge clk);
    apb_write(32'h0, 32'd3, 1'b0);
    rd("stat_ovr", 32'h4, 32'h5, 1'b0, 0);
    rd("ctrl_loop", 32'h0, 32'h2, 1'b0, 0);
    wait_sync(3, 20000);
    apb_write(32'h0, 32'd0, 1'b0);
    wait_idle(10000);
    check("sync_four", sync_cnt, 32'd4);
    rd("stat_end", 32'h4, {29'd0, mdl_ovr, mdl_done, mdl_active}, 1'b0, 0);

    // Two pixels per channel, then reset while ch1 is driving a '1' high phase.
    apb_write(32'h8, 32'd2, 1'b0);
    apb_write(32'h4, 32'h6, 1'b0);
    apb_write(32'h0, 32'd1, 1'b0);
    repeat (3030) @(posedge clk);
    #3;
    check("pre_rst_neo", neo, 32'h2);
    rst = 1'b1;
    mdl_active = 1'b0; mdl_len = PXM; mdl_loop = 1'b0; mdl_done = 1'b0; mdl_ovr = 1'b0;
    #1;
    check("rst_async", {neo, neo_state}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rd("len_after_rst", 32'h8, 32'd66, 1'b0, 0);
    rd("stat_after_rst", 32'h4, 32'd0, 1'b0, 0);
    rd("px_kept", pa(1, 1), 32'h00F0F0F0, 1'b0, 1);
    repeat (50) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
